// File: rtl/button_io.sv
// button_io: debounced push-button peripheral.
// Each raw button pin is synchronised through two flops, debounced with a
// per-button consecutive-mismatch counter, and exposed as a level register
// (addr bit 2 = 0). Optional rising-edge event flags (addr bit 2 = 1, W1C)
// are built only when the BTN_EVENT_EN macro is defined; otherwise EVENT
// reads return 0 and all writes are ignored.
module button_io #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int NUM_BTN         = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] button,
  input  logic [31:0]        addr_from_bridge,
  input  logic               we_from_bridge,
  input  logic [31:0]        wdata_from_bridge,
  output logic [31:0]        rdata_to_bridge
);

  // A width of at least one bit keeps DEBOUNCE_CYCLES == 1 legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] lvl;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] evt_rd;

  // Two-flop synchroniser for the asynchronous board pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // Debounce: the stable level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; one agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press detect: true on exactly the edge where lvl goes 0 -> 1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < NUM_BTN; i++)
      rise[i] = ~lvl[i] & s2[i] & (cnt[i] == CNT_MAX);
  end

`ifdef BTN_EVENT_EN
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] clr;

  // W1C mask: only writes to the EVENT register clear flags.
  always_comb begin
    clr = '0;
    if (we_from_bridge && addr_from_bridge[2])
      clr = wdata_from_bridge[NUM_BTN-1:0];
  end

  // Sticky press flags; a set on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) evt <= '0;
    else      evt <= (evt & ~clr) | rise;
  end

  assign evt_rd = evt;

  logic unused_bits;
  assign unused_bits = ^{addr_from_bridge[31:3], addr_from_bridge[1:0],
                         wdata_from_bridge[31:NUM_BTN]};
`else
  assign evt_rd = '0;

  logic unused_bits;
  assign unused_bits = ^{addr_from_bridge[31:3], addr_from_bridge[1:0],
                         wdata_from_bridge, we_from_bridge, rise};
`endif

  // Combinational read mux; reads have no side effects.
  always_comb begin
    rdata_to_bridge = '0;
    if (addr_from_bridge[2]) rdata_to_bridge = 32'(evt_rd);
    else                     rdata_to_bridge = 32'(lvl);
  end

endmodule

// File: tb/tb_button_io.sv
// Directed self-checking bench for button_io with DEBOUNCE_CYCLES=4,
// NUM_BTN=5. EVENT expectations follow the BTN_EVENT_EN build option.
module tb_button_io;

  localparam int DEB = 4;
  localparam int NB  = 5;
`ifdef BTN_EVENT_EN
  localparam bit EV_ON = 1'b1;
`else
  localparam bit EV_ON = 1'b0;
`endif
  localparam logic [31:0] A_LVL = 32'hFFFF_F070;
  localparam logic [31:0] A_EVT = 32'hFFFF_F074;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] button;
  logic [31:0]   addr_from_bridge;
  logic          we_from_bridge;
  logic [31:0]   wdata_from_bridge;
  logic [31:0]   rdata_to_bridge;

  int total = 0;
  int bad   = 0;

  button_io #(.DEBOUNCE_CYCLES(DEB), .NUM_BTN(NB)) dut (
    .clk               (clk),
    .rst               (rst),
    .button            (button),
    .addr_from_bridge  (addr_from_bridge),
    .we_from_bridge    (we_from_bridge),
    .wdata_from_bridge (wdata_from_bridge),
    .rdata_to_bridge   (rdata_to_bridge)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ev(input logic [31:0] v);
    return EV_ON ? v : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_lvl(input string tag, input logic [31:0] exp);
    addr_from_bridge = A_LVL;
    #1;
    chk(tag, rdata_to_bridge, exp);
  endtask

  task automatic chk_evt(input string tag, input logic [31:0] exp);
    addr_from_bridge = A_EVT;
    #1;
    chk(tag, rdata_to_bridge, ev(exp));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_from_bridge  = a;
    we_from_bridge    = 1'b1;
    wdata_from_bridge = d;
    tick();
    we_from_bridge    = 1'b0;
    wdata_from_bridge = 32'h0;
  endtask

  logic bounce_pat [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst               = 1'b0;
    button            = 5'h1F;
    addr_from_bridge  = A_LVL;
    we_from_bridge    = 1'b0;
    wdata_from_bridge = 32'h0;

    // Reset held for 3 edges with all buttons pressed.
    tick(3);
    chk_lvl("rst_lvl", 32'h0);
    chk_evt("rst_evt", 32'h0);
    rst = 1'b1;
    tick(5);
    chk_lvl("rst_rel_e5_lvl", 32'h0);
    tick();
    chk_lvl("rst_rel_e6_lvl", 32'h1F);
    chk_evt("rst_rel_e6_evt", 32'h1F);

    // W1C sequence.
    wr(A_EVT, 32'h0000_001A);
    chk_evt("w1c_1a", 32'h05);
    wr(A_EVT, 32'h0000_0004);
    chk_evt("w1c_04", 32'h01);
    wr(A_LVL, 32'h0000_00FF);
    chk_evt("w_lvl_evt", 32'h01);
    chk_lvl("w_lvl_lvl", 32'h1F);
    wr(A_EVT, 32'hFFFF_FFFF);
    chk_evt("w1c_all", 32'h00);

    // Release all: release sets no events.
    button = 5'h00;
    tick(5);
    chk_lvl("rel_e5_lvl", 32'h1F);
    tick();
    chk_lvl("rel_e6_lvl", 32'h00);
    chk_evt("rel_evt", 32'h00);

    // Clean press of button 2.
    button = 5'h04;
    tick(5);
    chk_lvl("press_e5_lvl", 32'h00);
    chk_evt("press_e5_evt", 32'h00);
    tick();
    chk_lvl("press_e6_lvl", 32'h04);
    chk_evt("press_e6_evt", 32'h04);
    button = 5'h00;
    tick(6);
    chk_lvl("press_rel_lvl", 32'h00);
    chk_evt("press_rel_evt", 32'h04);
    wr(A_EVT, 32'h0000_0004);
    chk_evt("press_clr", 32'h00);

    // Bounce on button 0: 3 high, 1 low, 3 high, then low.
    for (int k = 0; k < 14; k++) begin
      button = {4'b0, bounce_pat[k]};
      tick();
      chk_lvl($sformatf("bounce_lvl_%0d", k), 32'h00);
      chk_evt($sformatf("bounce_evt_%0d", k), 32'h00);
    end

    // Collision: W1C of bit 1 on the edge where lvl[1] rises.
    button = 5'h02;
    tick(5);
    chk_lvl("coll_e5_lvl", 32'h00);
    wr(A_EVT, 32'h0000_0002);
    chk_lvl("coll_e6_lvl", 32'h02);
    chk_evt("coll_e6_evt", 32'h02);
    button = 5'h00;
    tick(6);
    chk_lvl("coll_rel_lvl", 32'h00);
    chk_evt("coll_rel_evt", 32'h02);

    // Mid-debounce reset with button 0 held throughout.
    button = 5'h01;
    tick(4);
    chk_lvl("mid_pre_lvl", 32'h00);
    rst = 1'b0;
    tick();
    chk_lvl("mid_rst_lvl", 32'h00);
    chk_evt("mid_rst_evt", 32'h00);
    rst = 1'b1;
    tick(5);
    chk_lvl("mid_e5_lvl", 32'h00);
    chk_evt("mid_e5_evt", 32'h00);
    tick();
    chk_lvl("mid_e6_lvl", 32'h01);
    chk_evt("mid_e6_evt", 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
